// File: rtl/bcd_display_mux.sv
// bcd_display_mux: converts a 7-bit binary count into two BCD digits using an
// iterative shift-add-3 engine, then time-multiplexes the digits onto a
// 2-digit common-anode 7-segment display. A new conversion starts only when
// value_in differs from the last converted value.
module bcd_display_mux #(
   parameter int unsigned REFRESH_BITS = 16,
   parameter bit          BLANK_LEAD   = 1'b1
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [6:0] value_in,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       overflow,
   output logic       busy,
   output logic [6:0] seg,
   output logic [1:0] an
);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   state_t                  state;
   state_t                  state_next;
   logic [6:0]              last_val;
   logic [6:0]              shreg;
   logic [9:0]              bcd;
   logic [9:0]              bcd_adj;
   logic [2:0]              bit_cnt;
   logic                    start;
   logic                    step;
   logic                    load;
   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic                    digit_sel;
   logic [6:0]              seg_next;
   logic [1:0]              an_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // State register.
   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: 7 conversion steps, then one load cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (value_in != last_val) state_next = CONV;
         CONV:    if (bit_cnt == 3'd6) state_next = LOAD;
         LOAD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM control strobes for the datapath.
   always_comb begin
      start = (state == IDLE) && (value_in != last_val);
      step  = (state == CONV);
      load  = (state == LOAD);
   end

   // Add-3 correction on each BCD nibble that is 5 or more before shifting.
   always_comb begin
      bcd_adj = bcd;
      if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
   end

   // Conversion datapath and registered digit outputs.
   always_ff @(posedge CLK) begin
      if (reset) begin
         last_val <= '0;
         shreg    <= '0;
         bcd      <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
         tens     <= '0;
         ones     <= '0;
         overflow <= 1'b0;
      end else begin
         if (start) begin
            last_val <= value_in;
            shreg    <= value_in;
            bcd      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
         end
         if (step) begin
            bcd     <= {bcd_adj[8:0], shreg[6]};
            shreg   <= {shreg[5:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (load) begin
            tens     <= bcd[7:4];
            ones     <= bcd[3:0];
            overflow <= (bcd[9:8] != 2'd0);
            busy     <= 1'b0;
         end
      end
   end

   // Refresh counter; digit select flips on each counter wrap.
   always_ff @(posedge CLK) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_sel   <= 1'b0;
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
         if (refresh_cnt == '1) digit_sel <= ~digit_sel;
      end
   end

   // Segment pattern for the currently selected digit.
   always_comb begin
      if (!digit_sel) begin
         an_next  = 2'b10;
         seg_next = overflow ? SEG_DASH : decode(ones);
      end else begin
         an_next = 2'b01;
         if (overflow)                          seg_next = SEG_DASH;
         else if (BLANK_LEAD && tens == 4'd0)   seg_next = SEG_BLANK;
         else                                   seg_next = decode(tens);
      end
   end

   // Registered display drive.
   always_ff @(posedge CLK) begin
      if (reset) begin
         seg <= SEG_BLANK;
         an  <= 2'b11;
      end else begin
         seg <= seg_next;
         an  <= an_next;
      end
   end

endmodule
